// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern serial line: FSM states and line levels.
// Kept separate so a future deserializer can decode the same framing.
package pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam logic START_BIT    = 1'b0;
  localparam logic STOP_BIT     = 1'b1;
  localparam int   WORD_COUNT_W = 8;

endpackage

// File: rtl/par_gen.sv
// Parity generator: XOR-reduces a word, optionally inverted for odd parity.
module par_gen #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  assign parity_o = (^data_i) ^ ODD;

endmodule

// File: rtl/pattern_serializer.sv
// Serializes parallel pattern words into START / DATA(MSB first) / PARITY / STOP
// frames, with a one-word holding buffer so frames can run back-to-back.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter bit ODD_PAR   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    ser_out,
  output logic                    frame_active,
  output logic                    frame_done,
  output logic [WORD_COUNT_W-1:0] word_count
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                  state_q, state_d;
  logic                    buf_full_q, buf_full_d;
  logic [DATA_W-1:0]       buf_q, buf_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_COUNT_W-1:0] word_count_q, word_count_d;
  logic                    xfer;
  logic                    load;
  logic                    par_bit;

  // The shift register rotates rather than shifts, so its XOR is invariant
  // across the frame and parity can be taken from it directly.
  par_gen #(
    .WIDTH (DATA_W),
    .ODD   (ODD_PAR)
  ) u_par_gen (
    .data_i   (shift_q),
    .parity_o (par_bit)
  );

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (buf_full_q) state_d = ST_START;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   if (bit_cnt_q == LAST_BIT) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = buf_full_q ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = !buf_full_q;
    xfer         = in_valid && in_ready;
    // START lasts exactly one cycle, so heading into it marks a fresh entry.
    load         = (state_d == ST_START);

    buf_d        = xfer ? in_data : buf_q;
    buf_full_d   = buf_full_q;
    if (xfer) begin
      buf_full_d = 1'b1;
    end else if (load) begin
      buf_full_d = 1'b0;
    end

    shift_d      = shift_q;
    if (load) begin
      shift_d    = buf_q;
    end else if (state_q == ST_DATA) begin
      shift_d    = {shift_q[DATA_W-2:0], shift_q[DATA_W-1]};
    end

    bit_cnt_d    = '0;
    if (state_q == ST_DATA && bit_cnt_q != LAST_BIT) begin
      bit_cnt_d  = bit_cnt_q + CNT_ONE;
    end

    word_count_d = word_count_q;
    if (state_q == ST_STOP) begin
      word_count_d = word_count_q + WORD_COUNT_W'(1);
    end
  end

  always_comb begin
    ser_out      = STOP_BIT;
    frame_active = (state_q != ST_IDLE);
    frame_done   = (state_q == ST_STOP);
    word_count   = word_count_q;
    unique case (state_q)
      ST_IDLE:   ser_out = STOP_BIT;
      ST_START:  ser_out = START_BIT;
      ST_DATA:   ser_out = shift_q[DATA_W-1];
      ST_PARITY: ser_out = par_bit;
      ST_STOP:   ser_out = STOP_BIT;
      default:   ser_out = STOP_BIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      buf_full_q   <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      buf_full_q   <= buf_full_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  // NOTE: the buffer word carries no reset; it is only consumed while
  // buf_full_q is set, and that flag is reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench: three parity configurations driven with directed and
// random words, checked against a frame model built from the line format.
module tb_pattern_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data [3];
  logic       valid[3];
  logic       rdy  [3];
  logic       ser  [3];
  logic       act  [3];
  logic       done [3];
  logic [7:0] wc   [3];

  int vectors     = 0;
  int miscompares = 0;

  logic       rec_ser [64];
  logic       rec_act [64];
  logic       rec_done[64];
  logic       rec_rdy [64];
  logic [7:0] rec_wc  [64];
  logic [7:0] tx_words[4];
  logic [7:0] exp_q[$];

  pattern_serializer u_even (
    .clk(clk), .rst(rst), .in_data(data[0]), .in_valid(valid[0]), .in_ready(rdy[0]),
    .ser_out(ser[0]), .frame_active(act[0]), .frame_done(done[0]), .word_count(wc[0]));

  pattern_serializer #(.ODD_PAR(1'b1)) u_odd (
    .clk(clk), .rst(rst), .in_data(data[1]), .in_valid(valid[1]), .in_ready(rdy[1]),
    .ser_out(ser[1]), .frame_active(act[1]), .frame_done(done[1]), .word_count(wc[1]));

  pattern_serializer #(.PARITY_EN(1'b0)) u_nopar (
    .clk(clk), .rst(rst), .in_data(data[2]), .in_valid(valid[2]), .in_ready(rdy[2]),
    .ser_out(ser[2]), .frame_active(act[2]), .frame_done(done[2]), .word_count(wc[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Line model: start bit, data MSB first, optional parity, stop bit.
  function automatic logic exp_bit(input logic [7:0] w, input int idx, input bit par_en, input bit odd);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[8-idx];
    if (idx == 9 && par_en) return logic'(($countones(w) % 2) != 0) ^ odd;
    return 1'b1;
  endfunction

  function automatic logic [31:0] pack_ser(input int s, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], rec_ser[s+i]};
    return v;
  endfunction

  function automatic int count_act(input int s, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(rec_act[s+i]) + int'(rec_done[s+i]);
    return c;
  endfunction

  task automatic check_frame(input string tag, input int s, input logic [7:0] w,
                             input bit par_en, input bit odd);
    int          len;
    logic [31:0] o_ser, e_ser, o_act, e_act, o_done, e_done;
    len = par_en ? 11 : 10;
    o_ser = '0; e_ser = '0; o_act = '0; e_act = '0; o_done = '0; e_done = '0;
    for (int i = 0; i < len; i++) begin
      o_ser  = {o_ser[30:0], rec_ser[s+i]};
      e_ser  = {e_ser[30:0], exp_bit(w, i, par_en, odd)};
      o_act  = {o_act[30:0], rec_act[s+i]};
      e_act  = {e_act[30:0], 1'b1};
      o_done = {o_done[30:0], rec_done[s+i]};
      e_done = {e_done[30:0], logic'(i == len - 1)};
    end
    check({tag, "_bits"}, o_ser, e_ser);
    check({tag, "_active"}, o_act, e_act);
    check({tag, "_done"}, o_done, e_done);
  endtask

  // Offers tx_words[0..n-1] to one DUT, recording its outputs for ncyc cycles.
  // A non-negative rst_cyc raises rst for exactly that recorded cycle.
  task automatic run(input int sel, input int n, input int ncyc, input int rst_cyc);
    int   idx;
    logic xfer;
    idx        = 0;
    valid[sel] = (n > 0);
    data[sel]  = tx_words[0];
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rec_ser[c]  = ser[sel];
      rec_act[c]  = act[sel];
      rec_done[c] = done[sel];
      rec_rdy[c]  = rdy[sel];
      rec_wc[c]   = wc[sel];
      xfer = valid[sel] && rdy[sel] && !rst;
      @(posedge clk);
      #1;
      if (rst_cyc >= 0) rst = (c + 1 == rst_cyc);
      if (xfer) begin
        idx++;
        if (idx < n) data[sel] = tx_words[idx];
        else begin
          valid[sel] = 1'b0;
          data[sel]  = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    int done_cnt;
    int first0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0;
      data[k]  = 8'h00;
    end

    // Reset with a word offered on the reset edges: nothing may be captured.
    rst      = 1'b1;
    valid[0] = 1'b1;
    data[0]  = 8'hC3;
    @(negedge clk);
    check("rst_ser", ser[0], 1'b1);
    check("rst_active", act[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    valid[0] = 1'b0;
    @(negedge clk);
    check("rst_ready", rdy[0], 1'b1);
    check("rst_wc", wc[0], 8'd0);
    run(0, 0, 8, -1);
    check("rst_no_capture", pack_ser(0, 8), 32'hFF);
    check("rst_no_active", count_act(0, 8), 0);

    // 8'hA5, even parity: latency, exact line sequence, then idle and count.
    tx_words[0] = 8'hA5;
    run(0, 1, 16, -1);
    check("a5_latency_idle", rec_ser[1], 1'b1);
    check("a5_seq", pack_ser(2, 11), 32'b01010010101);
    check_frame("a5_even", 2, 8'hA5, 1'b1, 1'b0);
    check("a5_idle_after", rec_ser[13], 1'b1);
    check("a5_inactive_after", rec_act[13], 1'b0);
    check("a5_wc", rec_wc[15], 8'd1);

    // Odd parity on 8'hA5, even parity on 8'h01: parity bit is 1 in both.
    run(1, 1, 16, -1);
    check_frame("a5_odd", 2, 8'hA5, 1'b1, 1'b1);
    check("a5_odd_parity", rec_ser[11], 1'b1);
    tx_words[0] = 8'h01;
    run(0, 1, 16, -1);
    check_frame("h01_even", 2, 8'h01, 1'b1, 1'b0);
    check("h01_even_parity", rec_ser[11], 1'b1);

    // No parity, 8'h81: ten-cycle frame.
    tx_words[0] = 8'h81;
    run(2, 1, 16, -1);
    check("h81_nopar_seq", pack_ser(2, 10), 32'b0100000011);
    check_frame("h81_nopar", 2, 8'h81, 1'b0, 1'b0);
    check("h81_nopar_idle_after", rec_ser[12], 1'b1);

    // 8'hFF then 8'h00 back-to-back: contiguous frames, ready drops, two pulses.
    tx_words[0] = 8'hFF;
    tx_words[1] = 8'h00;
    run(0, 2, 30, -1);
    first0 = -1;
    for (int c = 0; c < 30; c++) if (first0 < 0 && rec_ser[c] == 1'b0) first0 = c;
    check("b2b_first_start", first0, 2);
    check_frame("b2b_ff", 2, 8'hFF, 1'b1, 1'b0);
    check_frame("b2b_00", 13, 8'h00, 1'b1, 1'b0);
    check("b2b_idle_after", rec_ser[24], 1'b1);
    check("b2b_ready_full1", rec_rdy[1], 1'b0);
    check("b2b_ready_full2", rec_rdy[3], 1'b0);
    done_cnt = 0;
    for (int c = 0; c < 30; c++) done_cnt += int'(rec_done[c]);
    check("b2b_done_pulses", done_cnt, 2);
    check("b2b_wc", rec_wc[29], 8'd4);

    // Reset during the 5th data bit of 8'h3C with 8'h55 buffered.
    tx_words[0] = 8'h3C;
    tx_words[1] = 8'h55;
    run(0, 2, 40, 7);
    check("rst_mid_pre", pack_ser(2, 6), {26'd0, exp_bit(8'h3C, 0, 1'b1, 1'b0),
          exp_bit(8'h3C, 1, 1'b1, 1'b0), exp_bit(8'h3C, 2, 1'b1, 1'b0),
          exp_bit(8'h3C, 3, 1'b1, 1'b0), exp_bit(8'h3C, 4, 1'b1, 1'b0),
          exp_bit(8'h3C, 5, 1'b1, 1'b0)});
    check("rst_mid_ser_next", rec_ser[8], 1'b1);
    check("rst_mid_line_idle", pack_ser(8, 32), 32'hFFFF_FFFF);
    check("rst_mid_no_frame", count_act(8, 32), 0);
    check("rst_mid_wc", rec_wc[39], 8'd0);
    check("rst_mid_ready", rec_rdy[39], 1'b1);

    // 256 random words with random gaps; the line is decoded and compared.
    fork
      begin : driver
        for (int w = 0; w < 256; w++) begin
          bit got;
          if ($urandom_range(0, 3) == 0) begin
            valid[0] = 1'b0;
            repeat ($urandom_range(1, 3)) begin
              data[0] = 8'($urandom);
              @(posedge clk);
              #1;
            end
          end
          valid[0] = 1'b1;
          data[0]  = 8'($urandom);
          got = 1'b0;
          for (int g = 0; g < 100 && !got; g++) begin
            @(negedge clk);
            got = rdy[0];
            @(posedge clk);
            #1;
          end
          if (!got) begin
            check("rand_drv_timeout", 0, 1);
            break;
          end
          exp_q.push_back(data[0]);
          valid[0] = 1'b0;
          data[0]  = 8'($urandom);
        end
        valid[0] = 1'b0;
      end
      begin : monitor
        for (int f = 0; f < 256; f++) begin
          bit          found;
          logic [31:0] o_v, e_v;
          logic [7:0]  w;
          found = 1'b0;
          for (int g = 0; g < 100 && !found; g++) begin
            @(negedge clk);
            found = (ser[0] == 1'b0);
          end
          if (!found) begin
            check("rand_mon_timeout", 0, 1);
            break;
          end
          o_v = 32'd0;
          for (int i = 1; i < 11; i++) begin
            @(negedge clk);
            o_v = {o_v[30:0], ser[0]};
          end
          check("rand_done", done[0], 1'b1);
          if (exp_q.size() > 0) begin
            w   = exp_q.pop_front();
            e_v = 32'd0;
            for (int i = 1; i < 11; i++) e_v = {e_v[30:0], exp_bit(w, i, 1'b1, 1'b0)};
          end else begin
            e_v = 32'hDEAD;
          end
          check("rand_frame", o_v, e_v);
          if (f == 255) check("rand_wc_255", wc[0], 8'd255);
        end
      end
    join
    repeat (3) @(negedge clk);
    check("rand_wc_wrap", wc[0], 8'd0);
    check("rand_idle", ser[0], 1'b1);
    check("rand_ready", rdy[0], 1'b1);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the parallel word width.
REQ-002 The block SHALL have parameter PARITY_EN, default 1; when 1, a parity bit is inserted before STOP.
REQ-003 The block SHALL have parameter ODD_PAR, default 0; 0 selects even parity, 1 selects odd parity.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  DATA_W  parallel pattern word from the upstream pattern generator.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 ser_out  output  1  serial line, idle high.
REQ-010 frame_active  output  1  high during the START, DATA, PARITY and STOP cycles.
REQ-011 frame_done  output  1  one-cycle pulse, asserted during the STOP cycle.
REQ-012 word_count  output  8  count of completed frames.

Function
REQ-013 A transfer SHALL occur on a rising edge where in_valid && in_ready; in_data is then captured into a 1-entry holding buffer.
REQ-014 in_ready SHALL equal !buf_full, combinationally from registered state.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with one cycle per serial bit.
REQ-016 FSM transitions SHALL be:
- IDLE -> START when buf_full.
- START -> DATA.
- DATA -> DATA until DATA_W bits have been sent, then PARITY if PARITY_EN, else STOP.
- PARITY -> STOP.
- STOP -> START if buf_full, else IDLE.
REQ-017 On each entry to START, the buffer word SHALL load into the shift register and buf_full SHALL clear, unless a new transfer occurs on the same edge, in which case buf_full stays 1 holding the new word.
REQ-018 ser_out SHALL be driven as follows:
- IDLE: 1.
- START: 0.
- DATA: shift register MSB first, bit index DATA_W-1 down to 0.
- PARITY: XOR of the word, inverted if ODD_PAR.
- STOP: 1.
REQ-019 Latency: a word accepted at edge N into an empty, idle block SHALL produce START on ser_out in the cycle after edge N+1.
REQ-020 Frame length SHALL be DATA_W+3 cycles with parity and DATA_W+2 cycles without parity.
REQ-021 Back-to-back words SHALL be sent with no IDLE gap between frames.
REQ-022 word_count SHALL increment on the edge leaving STOP and SHALL wrap from 255 to 0.
REQ-023 in_valid while in_ready=0 SHALL be ignored; the upstream holds the word, and it is not lost or duplicated.
REQ-024 in_data SHALL be sampled only at the transfer edge; later changes SHALL not affect a frame in flight.
REQ-025 The parity bit SHALL be computed from the loaded shift word, not from the live in_data.

Reset
REQ-026 While rst is 1 at a clock edge, the block SHALL set:
- state = IDLE;
- buf_full = 0;
- shift register = 0;
- bit counter = 0;
- word_count = 0.
REQ-027 Output values during and after reset SHALL be: ser_out=1, frame_active=0, frame_done=0, in_ready=1 (the in_ready=1 value applies after release).
REQ-028 Reset asserted mid-frame SHALL abort the frame and discard the buffered word; ser_out SHALL be 1 from the following cycle, with no partial frame completed.
REQ-029 No transfer SHALL be recorded on an edge where rst=1.

Structure
REQ-030 A shared package pattern_pkg SHALL hold the FSM state enum and the START_BIT=0 / STOP_BIT=1 constants, for reuse by a future deserializer.
REQ-031 Parity generation SHALL be a sub-module par_gen (parameterised by width and odd/even), instantiated once; everything else stays in pattern_serializer.

Verification
REQ-032 Reset, then in_data=8'hA5 held valid for one cycle: ser_out SHALL read 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, then return to idle 1, and word_count=1.
REQ-033 ODD_PAR=1 with 8'hA5: the parity cycle SHALL read 1; with 8'h01 under even parity, the parity cycle SHALL read 1.
REQ-034 8'hFF then 8'h00 sent back-to-back:
- frames SHALL be contiguous (STOP followed immediately by START);
- in_ready SHALL drop while the buffer is full;
- exactly 2 frame_done pulses SHALL occur.
REQ-035 rst pulsed at the 5th DATA bit of 8'h3C, with a second word buffered: ser_out SHALL be 1 the next cycle, word_count=0, and no further frame SHALL appear.
REQ-036 256 consecutive words SHALL leave word_count=0 (wrap), and each frame SHALL match a reference model.
REQ-037 PARITY_EN=0, 8'h81: ser_out SHALL read 0,1,0,0,0,0,0,0,1,1 (10 cycles).
